// File: rtl/axi_lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_slave_if
// Description : AXI-Lite AW/W/B/AR/R channel bundle with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WD = 8,
    parameter int DATA_WD = 8,
    parameter int STRB_WD = DATA_WD / 8
);
    logic               awvalid;
    logic               awready;
    logic [ADDR_WD-1:0] awaddr;
    logic               wvalid;
    logic               wready;
    logic [DATA_WD-1:0] wdata;
    logic [STRB_WD-1:0] wstrb;
    logic               bvalid;
    logic               bready;
    logic [1:0]         bresp;
    logic               arvalid;
    logic               arready;
    logic [ADDR_WD-1:0] araddr;
    logic               rvalid;
    logic               rready;
    logic [DATA_WD-1:0] rdata;
    logic [1:0]         rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_slave
// Description : AXI-Lite slave backed by a NUM_REGS x DATA_WD register file.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave #(
    parameter int DATA_WD  = 8,
    parameter int ADDR_WD  = 8,
    parameter int NUM_REGS = 16,
    parameter int STRB_WD  = DATA_WD / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_lite_reg_slave_if.slave  bus
);
    localparam int               IDX_WD      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WD:0] NUM_REGS_W  = (ADDR_WD + 1)'(NUM_REGS);

    logic [DATA_WD-1:0] regs_q [NUM_REGS];
    logic [DATA_WD-1:0] regs_d [NUM_REGS];
    logic               aw_held_q, aw_held_d;
    logic [ADDR_WD-1:0] awaddr_q,  awaddr_d;
    logic               w_held_q,  w_held_d;
    logic [DATA_WD-1:0] wdata_q,   wdata_d;
    logic [STRB_WD-1:0] wstrb_q,   wstrb_d;
    logic               bvalid_q,  bvalid_d;
    logic [1:0]         bresp_q,   bresp_d;
    logic               rvalid_q,  rvalid_d;
    logic [DATA_WD-1:0] rdata_q,   rdata_d;
    logic [1:0]         rresp_q,   rresp_d;

    logic               w_awready, w_wready, w_arready;
    logic               w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic               w_wr_in_range, w_rd_in_range;
    logic [IDX_WD-1:0]  w_wr_idx, w_rd_idx;

    // Ready stalls while a B response is pending so only one write is ever outstanding
    assign w_awready = !aw_held_q && !bvalid_q;
    assign w_wready  = !w_held_q  && !bvalid_q;
    assign w_arready = !rvalid_q;

    assign w_aw_hs  = bus.awvalid && w_awready;
    assign w_w_hs   = bus.wvalid  && w_wready;
    assign w_ar_hs  = bus.arvalid && w_arready;
    assign w_commit = aw_held_q && w_held_q && !bvalid_q;

    assign w_wr_in_range = {1'b0, awaddr_q}   < NUM_REGS_W;
    assign w_rd_in_range = {1'b0, bus.araddr} < NUM_REGS_W;
    assign w_wr_idx      = awaddr_q[IDX_WD-1:0];
    assign w_rd_idx      = bus.araddr[IDX_WD-1:0];

    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.arready = w_arready;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (w_aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = bus.awaddr;
        end
        if (w_w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = bus.wdata;
            wstrb_d  = bus.wstrb;
        end
        if (bvalid_q && bus.bready) begin
            bvalid_d = 1'b0;
        end
        if (w_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (w_wr_in_range) begin
                bresp_d = RESP_OKAY;
                for (int i = 0; i < STRB_WD; i++) begin
                    if (wstrb_q[i]) begin
                        regs_d[w_wr_idx][i*8 +: 8] = wdata_q[i*8 +: 8];
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
    end

    // Reads sample regs_q, so a same-edge write commit is not visible yet
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && bus.rready) begin
            rvalid_d = 1'b0;
        end
        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            if (w_rd_in_range) begin
                rdata_d = regs_q[w_rd_idx];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_reg_slave
// Description : Directed self-checking bench for axi_lite_reg_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_lite_reg_slave;
    localparam int DATA_WD  = 8;
    localparam int ADDR_WD  = 8;
    localparam int NUM_REGS = 16;
    localparam int STRB_WD  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    axi_lite_reg_slave_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .STRB_WD(STRB_WD)) bus ();

    axi_lite_reg_slave #(
        .DATA_WD (DATA_WD),
        .ADDR_WD (ADDR_WD),
        .NUM_REGS(NUM_REGS),
        .STRB_WD (STRB_WD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.bready  = 1'b1; bus.rready = 1'b1;
    endtask

    // Drives one write with AW and W together; reports B response or timeout
    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input logic strb,
                            output logic [1:0] resp, output bit to);
        bit aw_done, w_done, fire_aw, fire_w;
        aw_done = 0; w_done = 0; to = 1; resp = 2'bxx;
        tick();
        bus.awvalid = 1'b1; bus.awaddr = addr;
        bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
        bus.bready  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            fire_aw = bus.awvalid && bus.awready;
            fire_w  = bus.wvalid  && bus.wready;
            tick();
            if (fire_aw) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (fire_w)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            if (aw_done && w_done) break;
        end
        if (aw_done && w_done) begin
            for (int n = 0; n < 20; n++) begin
                if (bus.bvalid) begin resp = bus.bresp; to = 0; break; end
                tick();
            end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!to) tick();
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [7:0] data,
                           output logic [1:0] resp, output bit to);
        bit fire, done;
        done = 0; to = 1; data = 8'hxx; resp = 2'bxx;
        tick();
        bus.arvalid = 1'b1; bus.araddr = addr; bus.rready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            fire = bus.arvalid && bus.arready;
            tick();
            if (fire) begin bus.arvalid = 1'b0; done = 1; break; end
        end
        if (done) begin
            for (int n = 0; n < 20; n++) begin
                if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; to = 0; break; end
                tick();
            end
        end
        bus.arvalid = 1'b0;
        if (!to) tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL rst_awready got %b exp 1", bus.awready); end
        checks++; if (bus.wready  !== 1'b1) begin errors++; $display("FAIL rst_wready got %b exp 1", bus.wready); end
        checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL rst_arready got %b exp 1", bus.arready); end
        checks++; if (bus.bvalid  !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b exp 0", bus.bvalid); end
        checks++; if (bus.rvalid  !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", bus.rvalid); end
        checks++; if ({bus.bresp, bus.rresp, bus.rdata} !== 12'h000) begin errors++;
            $display("FAIL rst_resp_data got %h exp 000", {bus.bresp, bus.rresp, bus.rdata}); end
    endtask

    task automatic test_basic();
        tick();
        bus.awvalid = 1'b1; bus.awaddr = 8'h03;
        bus.wvalid  = 1'b1; bus.wdata  = 8'hA5; bus.wstrb = 1'b1;
        checks++; if ({bus.awready, bus.wready} !== 2'b11) begin errors++; $display("FAIL t1_ready got %b exp 11", {bus.awready, bus.wready}); end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL t1_bvalid_n1 got %b exp 0", bus.bvalid); end
        tick();
        checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL t1_bvalid_n2 got %b exp 1", bus.bvalid); end
        checks++; if (bus.bresp !== 2'b00) begin errors++; $display("FAIL t1_bresp got %b exp 00", bus.bresp); end
        tick();
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL t1_bclear got %b exp 0", bus.bvalid); end
        bus.arvalid = 1'b1; bus.araddr = 8'h03;
        checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL t1_arready got %b exp 1", bus.arready); end
        tick();
        bus.arvalid = 1'b0;
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL t1_rvalid got %b exp 1", bus.rvalid); end
        checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL t1_rdata got %h exp a5", bus.rdata); end
        checks++; if (bus.rresp !== 2'b00) begin errors++; $display("FAIL t1_rresp got %b exp 00", bus.rresp); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL t1_rclear got %b exp 0", bus.rvalid); end
    endtask

    task automatic test_w_before_aw();
        logic [7:0] d; logic [1:0] r; bit to;
        tick();
        bus.wvalid = 1'b1; bus.wdata = 8'h3C; bus.wstrb = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL t2_wready_held got %b exp 0", bus.wready); end
        tick();
        checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL t2_wready_held2 got %b exp 0", bus.wready); end
        tick();
        bus.awvalid = 1'b1; bus.awaddr = 8'h05;
        checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL t2_awready got %b exp 1", bus.awready); end
        tick();
        bus.awvalid = 1'b0;
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL t2_bvalid_early got %b exp 0", bus.bvalid); end
        tick();
        checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL t2_bvalid got %b exp 1", bus.bvalid); end
        tick();
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL t2_single_commit got %b exp 0", bus.bvalid); end
        do_read(8'h05, d, r, to);
        checks++; if (to || d !== 8'h3C) begin errors++; $display("FAIL t2_reg5 got %h to=%0d exp 3c", d, to); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] d; logic [1:0] r; bit to;
        do_write(8'h20, 8'hFF, 1'b1, r, to);
        checks++; if (to || r !== 2'b10) begin errors++; $display("FAIL t3_bresp got %b to=%0d exp 10", r, to); end
        do_read(8'h20, d, r, to);
        checks++; if (to || d !== 8'h00 || r !== 2'b10) begin errors++; $display("FAIL t3_read got %h/%b to=%0d exp 00/10", d, r, to); end
        do_read(8'h00, d, r, to);
        checks++; if (to || d !== 8'h00 || r !== 2'b00) begin errors++; $display("FAIL t3_reg0 got %h/%b exp 00/00", d, r); end
        do_read(8'h03, d, r, to);
        checks++; if (to || d !== 8'hA5) begin errors++; $display("FAIL t3_reg3 got %h exp a5", d); end
    endtask

    task automatic test_b_backpressure();
        logic [7:0] d; logic [1:0] r; bit to, seen;
        tick();
        bus.bready = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 8'h01;
        bus.wvalid  = 1'b1; bus.wdata  = 8'h5A; bus.wstrb = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            checks++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin errors++;
                $display("FAIL t4_bstall[%0d] got %b exp 10000", n, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); end
            if (n == 0) begin
                bus.awvalid = 1'b1; bus.awaddr = 8'h02;
                bus.wvalid  = 1'b1; bus.wdata  = 8'h77;
            end
            tick();
        end
        bus.bready = 1'b1;
        tick();
        checks++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin errors++;
            $display("FAIL t4_after_b got %b exp 011", {bus.bvalid, bus.awready, bus.wready}); end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.bvalid) begin seen = 1; break; end
            tick();
        end
        checks++; if (!seen || bus.bresp !== 2'b00) begin errors++; $display("FAIL t4_second_b got seen=%0d resp=%b exp 1/00", seen, bus.bresp); end
        tick();
        do_read(8'h02, d, r, to);
        checks++; if (to || d !== 8'h77) begin errors++; $display("FAIL t4_reg2 got %h exp 77", d); end
    endtask

    task automatic test_r_backpressure();
        tick();
        bus.rready = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 8'h01;
        tick();
        bus.araddr = 8'h03;
        for (int n = 0; n < 5; n++) begin
            checks++; if ({bus.rvalid, bus.rdata, bus.rresp, bus.arready} !== {1'b1, 8'h5A, 2'b00, 1'b0}) begin errors++;
                $display("FAIL t4_rstall[%0d] got %b/%h/%b/%b exp 1/5a/00/0", n, bus.rvalid, bus.rdata, bus.rresp, bus.arready); end
            tick();
        end
        bus.rready = 1'b1;
        tick();
        checks++; if ({bus.rvalid, bus.arready} !== 2'b01) begin errors++; $display("FAIL t4_rclear got %b exp 01", {bus.rvalid, bus.arready}); end
        tick();
        bus.arvalid = 1'b0;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 8'hA5) begin errors++; $display("FAIL t4_next_read got %b/%h exp 1/a5", bus.rvalid, bus.rdata); end
        tick();
    endtask

    task automatic test_same_edge();
        logic [7:0] d; logic [1:0] r; bit to;
        do_write(8'h07, 8'h11, 1'b1, r, to);
        tick();
        bus.awvalid = 1'b1; bus.awaddr = 8'h07;
        bus.wvalid  = 1'b1; bus.wdata  = 8'h99; bus.wstrb = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 8'h07;
        tick();
        bus.arvalid = 1'b0;
        checks++; if ({bus.rvalid, bus.bvalid} !== 2'b11 || bus.rdata !== 8'h11) begin errors++;
            $display("FAIL t5_same_edge got r%b b%b %h exp 1 1 11", bus.rvalid, bus.bvalid, bus.rdata); end
        tick();
        do_read(8'h07, d, r, to);
        checks++; if (to || d !== 8'h99) begin errors++; $display("FAIL t5_new_value got %h exp 99", d); end
        do_write(8'h07, 8'h00, 1'b0, r, to);
        checks++; if (to || r !== 2'b00) begin errors++; $display("FAIL t5_strb0_bresp got %b exp 00", r); end
        do_read(8'h07, d, r, to);
        checks++; if (to || d !== 8'h99) begin errors++; $display("FAIL t5_strb0_reg got %h exp 99", d); end
    endtask

    task automatic test_reset_inflight();
        logic [7:0] d; logic [1:0] r; bit to;
        tick();
        bus.rready = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 8'h04;
        bus.arvalid = 1'b1; bus.araddr = 8'h03;
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        checks++; if ({bus.awready, bus.rvalid} !== 2'b01) begin errors++; $display("FAIL t6_pre got %b exp 01", {bus.awready, bus.rvalid}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin errors++; $display("FAIL t6_async got %b exp 00", {bus.bvalid, bus.rvalid}); end
        tick();
        tick();
        rst_n = 1'b1;
        bus.rready = 1'b1;
        bus.wvalid = 1'b1; bus.wdata = 8'hEE; bus.wstrb = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin errors++; $display("FAIL t6_no_resp[%0d] got %b exp 00", n, {bus.bvalid, bus.rvalid}); end
            tick();
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            do_read(8'(i), d, r, to);
            checks++; if (to || d !== 8'h00) begin errors++; $display("FAIL t6_reg[%0d] got %h to=%0d exp 00", i, d, to); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_out_of_range();
        test_b_backpressure();
        test_r_backpressure();
        test_same_edge();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
